// File: rtl/zxnet_usb_cpld_pkg.sv
// Shared constants for the ZX-Spectrum W5300/SL811 glue: port addresses,
// register bit positions and the W5300 memory-window remap patterns.
package zxnet_usb_cpld_pkg;

  localparam logic [15:0] PORT_RSTINT = 16'h83AB;
  localparam logic [15:0] PORT_W5CFG  = 16'h82AB;
  localparam logic [15:0] PORT_SLCFG  = 16'h81AB;
  localparam logic [15:0] PORT_SLADDR = 16'h80AB;

  localparam int RI_W5_INT  = 0;
  localparam int RI_SL_INT  = 1;
  localparam int RI_W5_EN   = 2;
  localparam int RI_SL_EN   = 3;
  localparam int RI_W5_RST  = 4;
  localparam int RI_SL_RST  = 5;
  localparam int RI_EXT_EN  = 6;
  localparam int RI_IRQ     = 7;
  localparam logic [7:0] RSTINT_WR_MASK = 8'h7C;

  localparam int WC_PAGE_LO   = 0;
  localparam int WC_PAGE_HI   = 1;
  localparam int WC_SUB_ENA   = 2;
  localparam int WC_A0_INV    = 3;
  localparam int WC_PORT_MODE = 4;
  localparam int WC_ADDR_LO   = 5;
  localparam int WC_ADDR_HI   = 7;

  localparam int SC_MS      = 0;
  localparam int SC_USB_PWR = 1;

  localparam logic [13:0] WIN_A_BASE = 14'h2000;
  localparam logic [13:0] WIN_B_BASE = 14'h3000;
  localparam logic [4:0]  FILL_A     = 5'b10111;
  localparam logic [4:0]  FILL_B     = 5'b11000;

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_W5300,
    TGT_SL811
  } target_e;

endpackage

// File: rtl/zxnet_usb_cpld_if.sv
// Z80-side address/strobe bundle; the CPU (or bench) is master, the CPLD slave.
interface zxnet_usb_cpld_if;
  logic [15:0] za;
  logic        ziorq_n;
  logic        zmreq_n;
  logic        zrd_n;
  logic        zwr_n;
  logic        zcsrom_n;
  logic        ziorqge;
  logic        zblkrom;

  modport master (
    output za, ziorq_n, zmreq_n, zrd_n, zwr_n, zcsrom_n,
    input  ziorqge, zblkrom
  );

  modport slave (
    input  za, ziorq_n, zmreq_n, zrd_n, zwr_n, zcsrom_n,
    output ziorqge, zblkrom
  );
endinterface

// File: rtl/zxnet_usb_cpld_w5300_addr_map.sv
// Folds a 14-bit ROM-window offset onto the 10-bit W5300 address space.
module zxnet_usb_cpld_w5300_addr_map
  import zxnet_usb_cpld_pkg::*;
(
  input  logic [13:0] offset,
  input  logic        a0_inv,
  output logic [9:0]  addr
);
  logic [9:0] base;

  // Lower 8 KB aliases the direct register space; the upper two 4 KB
  // halves land on the TX/RX FIFO register pairs of each socket.
  always_comb begin
    if (offset < WIN_A_BASE) begin
      base = offset[9:0];
    end else if (offset < WIN_B_BASE) begin
      base = {1'b1, offset[11:9], FILL_A, offset[0]};
    end else begin
      base = {1'b1, offset[11:9], FILL_B, offset[0]};
    end
    addr = {base[9:1], base[0] ^ a0_inv};
  end
endmodule

// File: rtl/zxnet_usb_cpld.sv
// Glue between a ZX-Spectrum Z80 bus, a W5300 Ethernet chip and an SL811 USB host.
// Optional macro INT_SYNC_EN: two-flop synchronisers on the interrupt/VBUS inputs.
module zxnet_usb_cpld
  import zxnet_usb_cpld_pkg::*;
#(
  parameter logic [7:0] PORT_LO = 8'hAB
) (
  input  logic            clk,
  input  logic            zrst_n,
  zxnet_usb_cpld_if.slave zbus,
  inout  wire  [7:0]      zd,
  output wire             zint_n,
  inout  wire  [7:0]      bd,
  output logic            brd_n,
  output logic            bwr_n,
  output logic            w5300_rst_n,
  output logic            w5300_cs_n,
  output logic [9:0]      w5300_addr,
  input  logic            w5300_int_n,
  output logic            sl811_rst_n,
  output logic            sl811_cs_n,
  output logic            sl811_a0,
  output logic            sl811_ms_n,
  input  logic            sl811_intrq,
  input  logic            usb_power
);
  logic [7:0] ctl_q;
  logic [7:0] w5cfg_q;
  logic       ms_q;
  logic       w5_int, sl_int, pwr, irq;
  logic       io_hit, sel_rstint, sel_w5cfg, sel_slcfg, sel_sladdr, sel_data;
  logic       mem_sel, reg_rd, periph_rd, periph_wr;
  logic [7:0] reg_val;
  logic [9:0] mem_addr, io_addr;
  target_e    target;

`ifdef INT_SYNC_EN
  logic [2:0] stat_p0, stat_p1;

  // Stage boundary: asynchronous peripheral status into the clk domain.
  always_ff @(posedge clk or negedge zrst_n) begin
    if (!zrst_n) begin
      stat_p0 <= '0;
      stat_p1 <= '0;
    end else begin
      stat_p0 <= {usb_power, sl811_intrq, ~w5300_int_n};
      stat_p1 <= stat_p0;
    end
  end
  assign {pwr, sl_int, w5_int} = stat_p1;
`else
  assign {pwr, sl_int, w5_int} = {usb_power, sl811_intrq, ~w5300_int_n};
`endif

  // Everything is gated by reset so an access in flight drops at once.
  assign io_hit     = zrst_n && !zbus.ziorq_n && (zbus.za[7:0] == PORT_LO);
  assign sel_rstint = io_hit && (zbus.za[15:8] == PORT_RSTINT[15:8]);
  assign sel_w5cfg  = io_hit && (zbus.za[15:8] == PORT_W5CFG[15:8]);
  assign sel_slcfg  = io_hit && (zbus.za[15:8] == PORT_SLCFG[15:8]);
  assign sel_sladdr = io_hit && (zbus.za[15:8] == PORT_SLADDR[15:8]);
  assign sel_data   = io_hit && !zbus.za[15];
  assign zbus.ziorqge = sel_rstint | sel_w5cfg | sel_slcfg | sel_sladdr | sel_data;

  always_ff @(posedge clk or negedge zrst_n) begin
    if (!zrst_n) begin
      ctl_q   <= '0;
      w5cfg_q <= '0;
      ms_q    <= 1'b0;
    end else if (!zbus.zwr_n) begin
      if (sel_rstint) ctl_q <= zd & RSTINT_WR_MASK;
      if (sel_w5cfg)  w5cfg_q <= zd;
      if (sel_slcfg)  ms_q <= zd[SC_MS];
    end
  end

  assign irq = |({sl_int, w5_int} & {ctl_q[RI_SL_EN], ctl_q[RI_W5_EN]});
  assign zint_n = (ctl_q[RI_EXT_EN] && irq) ? 1'b0 : 1'bz;

  assign w5300_rst_n = ctl_q[RI_W5_RST];
  assign sl811_rst_n = ctl_q[RI_SL_RST];
  assign sl811_ms_n  = ~(ms_q | ~ctl_q[RI_SL_RST]);

  always_comb begin
    reg_val = 8'h00;
    if (sel_rstint) begin
      reg_val            = ctl_q;
      reg_val[RI_W5_INT] = w5_int;
      reg_val[RI_SL_INT] = sl_int;
      reg_val[RI_IRQ]    = irq;
    end else if (sel_w5cfg) begin
      reg_val = w5cfg_q;
    end else if (sel_slcfg) begin
      reg_val[SC_MS]      = ms_q;
      reg_val[SC_USB_PWR] = pwr;
    end
  end
  assign reg_rd = (sel_rstint | sel_w5cfg | sel_slcfg) && !zbus.zrd_n;

  assign mem_sel = zrst_n && !zbus.zmreq_n && !zbus.zcsrom_n && w5cfg_q[WC_SUB_ENA]
                   && (zbus.za[15:14] == w5cfg_q[WC_PAGE_HI:WC_PAGE_LO]);
  assign zbus.zblkrom = mem_sel;

  always_comb begin
    target = TGT_NONE;
    if (mem_sel || (sel_data && w5cfg_q[WC_PORT_MODE])) begin
      target = TGT_W5300;
    end else if (sel_sladdr || sel_data) begin
      target = TGT_SL811;
    end
  end

  zxnet_usb_cpld_w5300_addr_map u_addr_map (
    .offset (zbus.za[13:0]),
    .a0_inv (w5cfg_q[WC_A0_INV]),
    .addr   (mem_addr)
  );

  assign io_addr    = {w5cfg_q[WC_ADDR_HI:WC_ADDR_LO], zbus.za[14:8]}
                      ^ {9'b0, w5cfg_q[WC_A0_INV]};
  assign w5300_addr = mem_sel ? mem_addr : io_addr;
  assign w5300_cs_n = (target != TGT_W5300);
  assign sl811_cs_n = (target != TGT_SL811);
  assign sl811_a0   = sel_data;

  assign brd_n     = (target == TGT_NONE) | zbus.zrd_n;
  assign bwr_n     = (target == TGT_NONE) | zbus.zwr_n;
  assign periph_rd = (target != TGT_NONE) && !zbus.zrd_n;
  assign periph_wr = (target != TGT_NONE) && !zbus.zwr_n;

  assign zd = reg_rd ? reg_val : (periph_rd ? bd : 8'hzz);
  assign bd = periph_wr ? zd : 8'hzz;
endmodule

// File: tb/tb_zxnet_usb_cpld.sv
// Randomised bench for zxnet_usb_cpld with an in-bench behavioural model.
module tb_zxnet_usb_cpld;
  logic clk = 1'b0;
  logic zrst_n = 1'b0;
  always #5 clk = ~clk;

  zxnet_usb_cpld_if zbus();
  wire [7:0] zd;
  wire [7:0] bd;
  wire       zint_n;
  pullup (zint_n);

  logic       zd_oe = 1'b0, bd_oe = 1'b0;
  logic [7:0] zd_drv = 8'h00, bd_drv = 8'h00;
  assign zd = zd_oe ? zd_drv : 8'hzz;
  assign bd = bd_oe ? bd_drv : 8'hzz;

  logic       brd_n, bwr_n, w5300_rst_n, w5300_cs_n;
  logic       sl811_rst_n, sl811_cs_n, sl811_a0, sl811_ms_n;
  logic [9:0] w5300_addr;
  logic       w5300_int_n = 1'b1, sl811_intrq = 1'b0, usb_power = 1'b0;

  zxnet_usb_cpld dut (
    .clk(clk), .zrst_n(zrst_n), .zbus(zbus), .zd(zd), .zint_n(zint_n), .bd(bd),
    .brd_n(brd_n), .bwr_n(bwr_n), .w5300_rst_n(w5300_rst_n), .w5300_cs_n(w5300_cs_n),
    .w5300_addr(w5300_addr), .w5300_int_n(w5300_int_n), .sl811_rst_n(sl811_rst_n),
    .sl811_cs_n(sl811_cs_n), .sl811_a0(sl811_a0), .sl811_ms_n(sl811_ms_n),
    .sl811_intrq(sl811_intrq), .usb_power(usb_power)
  );

  // Model state: register contents as the CPU has written them.
  logic [7:0] m_ctl = 8'h00, m_w5cfg = 8'h00;
  logic       m_ms = 1'b0;
  int         n_checks = 0, n_err = 0;
  bit         chk_en = 0;

  // Status as seen by the design: {usb_power, sl811 int, w5300 int}.
  logic [2:0] stat;
`ifdef INT_SYNC_EN
  logic [2:0] h0 = 3'b000, h1 = 3'b000;
  always @(posedge clk or negedge zrst_n) begin
    if (!zrst_n) begin
      h0 = 3'b000; h1 = 3'b000;
    end else begin
      h1 = h0; h0 = {usb_power, sl811_intrq, ~w5300_int_n};
    end
  end
  assign stat = h1;
`else
  assign stat = {usb_power, sl811_intrq, ~w5300_int_n};
`endif

  logic [7:0] s_zd, s_bd;
  logic [9:0] s_addr;
  logic       s_w5cs, s_slcs, s_a0, s_brd, s_bwr, s_blk, s_ge;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int mem_map(int o, bit inv);
    int r;
    if (o < 8192) r = o % 1024;
    else r = 512 + ((o / 512) % 8) * 64 + ((o < 12288) ? 46 : 48) + (o % 2);
    return r ^ int'(inv);
  endfunction

  task automatic compare_now();
    bit rst, iodec, mem, w5acc, slacc, irq;
    int kind, hi, ea;
    logic [7:0] rv;
    rst   = (zrst_n === 1'b1);
    hi    = int'(zbus.za[15:8]);
    iodec = rst && !zbus.ziorq_n && (zbus.za[7:0] == 8'hAB);
    kind  = 0;
    if (iodec) begin
      if (hi < 128) kind = 5;
      else if (hi == 'h83) kind = 1;
      else if (hi == 'h82) kind = 2;
      else if (hi == 'h81) kind = 3;
      else if (hi == 'h80) kind = 4;
    end
    mem   = rst && !zbus.zmreq_n && !zbus.zcsrom_n && m_w5cfg[2]
            && (int'(zbus.za[15:14]) == int'(m_w5cfg[1:0]));
    w5acc = mem || (kind == 5 && m_w5cfg[4]);
    slacc = !w5acc && (kind == 4 || kind == 5);
    irq   = (stat[0] && m_ctl[2]) || (stat[1] && m_ctl[3]);
    check("ziorqge", 16'(zbus.ziorqge), 16'(kind != 0));
    check("zblkrom", 16'(zbus.zblkrom), 16'(mem));
    check("w5300_cs_n", 16'(w5300_cs_n), 16'(!w5acc));
    check("sl811_cs_n", 16'(sl811_cs_n), 16'(!slacc));
    check("brd_n", 16'(brd_n), 16'((w5acc || slacc) ? zbus.zrd_n : 1'b1));
    check("bwr_n", 16'(bwr_n), 16'((w5acc || slacc) ? zbus.zwr_n : 1'b1));
    check("w5300_rst_n", 16'(w5300_rst_n), 16'(m_ctl[4]));
    check("sl811_rst_n", 16'(sl811_rst_n), 16'(m_ctl[5]));
    check("sl811_ms_n", 16'(sl811_ms_n), 16'(!(m_ms || !m_ctl[5])));
    check("zint_n", 16'(zint_n), 16'(!(m_ctl[6] && irq)));
    if (w5acc) begin
      if (mem) ea = mem_map(int'(zbus.za[13:0]), m_w5cfg[3]);
      else ea = (int'(m_w5cfg[7:5]) * 128 + int'(zbus.za[14:8])) ^ int'(m_w5cfg[3]);
      check("w5300_addr", 16'(w5300_addr), 16'(ea));
    end
    if (slacc) check("sl811_a0", 16'(sl811_a0), 16'(kind == 5));
    if (!zbus.zrd_n && kind >= 1 && kind <= 3) begin
      if (kind == 1) rv = {irq, m_ctl[6:2], stat[1], stat[0]};
      else if (kind == 2) rv = m_w5cfg;
      else rv = {6'b0, stat[2], m_ms};
      check("zd_reg", 16'(zd), 16'(rv));
    end else if (!zbus.zrd_n && (w5acc || slacc)) begin
      check("zd_periph", 16'(zd), 16'(bd_drv));
    end
    if (!zbus.zwr_n && (w5acc || slacc)) check("bd_write", 16'(bd), 16'(zd_drv));
  endtask

  always @(negedge clk) if (chk_en) compare_now();

  task automatic idle();
    zbus.za = 16'h0000; zbus.ziorq_n = 1'b1; zbus.zmreq_n = 1'b1;
    zbus.zrd_n = 1'b1; zbus.zwr_n = 1'b1; zbus.zcsrom_n = 1'b1;
    zd_oe = 1'b0; bd_oe = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus cycle, entered and left just after a rising edge.
  task automatic cycle(input logic [15:0] a, input bit io, input bit wr,
                       input logic [7:0] d, input bit rom);
    zbus.za = a; zbus.ziorq_n = !io; zbus.zmreq_n = io;
    zbus.zrd_n = wr; zbus.zwr_n = !wr; zbus.zcsrom_n = !rom;
    zd_oe = wr; zd_drv = d; bd_oe = !wr; bd_drv = d;
    @(negedge clk); #1;
    s_zd = zd; s_bd = bd; s_addr = w5300_addr; s_w5cs = w5300_cs_n; s_slcs = sl811_cs_n;
    s_a0 = sl811_a0; s_brd = brd_n; s_bwr = bwr_n; s_blk = zbus.zblkrom; s_ge = zbus.ziorqge;
    @(posedge clk);
    if (wr && io && a[7:0] == 8'hAB && zrst_n) begin
      case (a[15:8])
        8'h83: m_ctl = d & 8'h7C;
        8'h82: m_w5cfg = d;
        8'h81: m_ms = d[0];
        default: ;
      endcase
    end
    #1 idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    bit io, wr, rom;
    idle();
    chk_en = 1;
    wait_cycles(3);
    zrst_n = 1'b1;
    wait_cycles(3);

    check("rst w5300_rst_n", 16'(w5300_rst_n), 16'h0);
    check("rst sl811_rst_n", 16'(sl811_rst_n), 16'h0);
    check("rst zint_n", 16'(zint_n), 16'h1);
    cycle(16'h83AB, 1, 0, 8'h00, 0);
    check("rst read 83AB", 16'(s_zd), 16'h00);
    check("rst ziorqge", 16'(s_ge), 16'h1);

    cycle(16'h83AB, 1, 1, 8'h20, 0);
    check("sl811 out of reset", 16'(sl811_rst_n), 16'h1);
    check("w5300 still reset", 16'(w5300_rst_n), 16'h0);
    cycle(16'h83AB, 1, 0, 8'h00, 0);
    check("read 83AB rst bits", 16'(s_zd), 16'h20);

    sl811_intrq = 1'b1; w5300_int_n = 1'b1;
    wait_cycles(3);
    cycle(16'h83AB, 1, 1, 8'h48, 0);
    cycle(16'h83AB, 1, 0, 8'h00, 0);
    check("read 83AB irq", 16'(s_zd), 16'hCA);
    check("zint_n asserted", 16'(zint_n), 16'h0);
    cycle(16'h83AB, 1, 1, 8'h08, 0);
    check("zint_n released", 16'(zint_n), 16'h1);
    sl811_intrq = 1'b0;

    cycle(16'h82AB, 1, 1, 8'h0D, 0);
    cycle(16'h6001, 0, 1, 8'h5A, 1);
    check("mem 0x2001 addr", 16'(s_addr), 16'h22E);
    check("mem blkrom", 16'(s_blk), 16'h1);
    check("mem cs_n", 16'(s_w5cs), 16'h0);
    check("mem bd", 16'(s_bd), 16'h5A);
    cycle(16'h4001, 0, 0, 8'hC3, 1);
    check("mem 0x0001 addr", 16'(s_addr), 16'h000);
    check("mem read zd", 16'(s_zd), 16'hC3);
    cycle(16'h5FFF, 0, 0, 8'h11, 1);
    check("mem 0x1FFF addr", 16'(s_addr), 16'h3FE);
    cycle(16'h7000, 0, 0, 8'h22, 1);
    check("mem 0x3000 addr", 16'(s_addr), 16'h231);
    cycle(16'h7FFF, 0, 1, 8'h33, 1);
    check("mem 0x3FFF addr", 16'(s_addr), 16'h3F0);
    cycle(16'hA001, 0, 0, 8'h44, 1);
    check("page mismatch cs_n", 16'(s_w5cs), 16'h1);
    check("page mismatch brd_n", 16'(s_brd), 16'h1);
    check("page mismatch blkrom", 16'(s_blk), 16'h0);

    cycle(16'h82AB, 1, 1, 8'hB0, 0);
    cycle(16'h12AB, 1, 0, 8'h3C, 0);
    check("port mode addr", 16'(s_addr), 16'h292);
    check("port mode zd", 16'(s_zd), 16'h3C);
    check("port mode cs_n", 16'(s_w5cs), 16'h0);
    check("port mode sl cs_n", 16'(s_slcs), 16'h1);

    cycle(16'h82AB, 1, 1, 8'h00, 0);
    cycle(16'h83AB, 1, 1, 8'h20, 0);
    check("ms_n idle", 16'(sl811_ms_n), 16'h1);
    cycle(16'h80AB, 1, 1, 8'h77, 0);
    check("sladdr cs_n", 16'(s_slcs), 16'h0);
    check("sladdr a0", 16'(s_a0), 16'h0);
    check("sladdr bd", 16'(s_bd), 16'h77);
    check("sladdr bwr_n", 16'(s_bwr), 16'h0);
    cycle(16'h55AB, 1, 0, 8'h9E, 0);
    check("data a0", 16'(s_a0), 16'h1);
    check("data brd_n", 16'(s_brd), 16'h0);
    check("data zd", 16'(s_zd), 16'h9E);
    cycle(16'h81AB, 1, 1, 8'h01, 0);
    check("ms_n set", 16'(sl811_ms_n), 16'h0);
    usb_power = 1'b1;
    wait_cycles(3);
    cycle(16'h81AB, 1, 0, 8'h00, 0);
    check("slcfg read", 16'(s_zd), 16'h03);

    // Reset asserted in the middle of a peripheral read.
    zbus.za = 16'h55AB; zbus.ziorq_n = 1'b0; zbus.zrd_n = 1'b0; bd_oe = 1'b1; bd_drv = 8'h66;
    #2;
    check("pre-reset brd_n", 16'(brd_n), 16'h0);
    zrst_n = 1'b0; m_ctl = 8'h00; m_w5cfg = 8'h00; m_ms = 1'b0;
    #1;
    check("mid-reset brd_n", 16'(brd_n), 16'h1);
    check("mid-reset sl cs_n", 16'(sl811_cs_n), 16'h1);
    check("mid-reset ziorqge", 16'(zbus.ziorqge), 16'h0);
    wait_cycles(2);
    idle();
    wait_cycles(1);
    zrst_n = 1'b1;
    wait_cycles(2);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        w5300_int_n = 1'($urandom);
        sl811_intrq = 1'($urandom);
        usb_power   = 1'($urandom);
      end
      if (i % 50 == 0) begin
        cycle(16'h82AB, 1, 1, 8'($urandom) | 8'h04, 0);
        continue;
      end
      rom = 0; io = 1;
      case ($urandom_range(0, 4))
        0: a = {6'h20, 2'($urandom), 8'hAB};
        1: a = {1'b0, 7'($urandom), 8'hAB};
        2: a = 16'($urandom);
        default: begin
          a = 16'($urandom); io = 0; rom = ($urandom_range(0, 3) != 0);
        end
      endcase
      wr = 1'($urandom);
      cycle(a, io, wr, 8'($urandom), rom);
    end

    wait_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
